// File: rtl/rib_wait_slave.sv
// Word-addressed memory slave on the core bus that stalls the pipeline for a
// fixed number of wait cycles per access and flags out-of-window requests.
module rib_wait_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        err_o,
  output logic        err_sticky_o
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        w_offset;
  logic               w_hit;
  logic               w_accept;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic               r_err_sticky;
  logic [31:0]        r_mem [DEPTH];

  // Unsigned wrap makes addresses below the base land far outside the span.
  assign w_offset = addr_i - BASE_ADDR;
  assign w_hit    = (w_offset < SPAN);
  assign w_accept = (r_state == S_IDLE) && req_i && w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    hold_flag_o = 1'b0;
    err_o       = 1'b0;
    data_o      = 32'h0;
    unique case (r_state)
      S_IDLE: begin
        if (req_i && w_hit) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          hold_flag_o = !rst;
        end else if (req_i) begin
          err_o = !rst;
        end
      end
      S_WAIT: begin
        hold_flag_o = !rst;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!rst && !r_we) begin
          data_o = r_mem[r_idx];
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture registers, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_we         <= 1'b0;
      r_wdata      <= 32'h0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= WAIT_LD;
        r_idx   <= w_offset[IDX_W+1:2];
        r_we    <= we_i;
        r_wdata <= data_i;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (err_o) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  // Storage is never reset; a reset during DONE suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_DONE) && r_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign err_sticky_o = r_err_sticky;

endmodule

// File: tb/tb_rib_wait_slave.sv
// Directed bench for rib_wait_slave: two instances (2 wait cycles, 0 wait
// cycles) sharing we/addr/data, with a scoreboard queue of expected read data.
module tb_rib_wait_slave;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, we;
  logic [31:0] addr, wdata;
  logic [31:0] data_a, data_b;
  logic        hold_a, hold_b, err_a, err_b, stk_a, stk_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mem_a[int];
  logic [31:0] mem_b[int];

  rib_wait_slave #(.BASE_ADDR(BASE), .DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_i(req_a), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(data_a), .hold_flag_o(hold_a), .err_o(err_a), .err_sticky_o(stk_a)
  );

  rib_wait_slave #(.BASE_ADDR(BASE), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(data_b), .hold_flag_o(hold_b), .err_o(err_b), .err_sticky_o(stk_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic logic o_hold(input int sel);
    return (sel != 0) ? hold_b : hold_a;
  endfunction

  function automatic logic o_err(input int sel);
    return (sel != 0) ? err_b : err_a;
  endfunction

  function automatic logic o_stk(input int sel);
    return (sel != 0) ? stk_b : stk_a;
  endfunction

  function automatic logic [31:0] o_data(input int sel);
    return (sel != 0) ? data_b : data_a;
  endfunction

  function automatic logic [31:0] model_rd(input int sel, input int idx);
    if (sel != 0) return mem_b.exists(idx) ? mem_b[idx] : 32'h0;
    return mem_a.exists(idx) ? mem_a[idx] : 32'h0;
  endfunction

  task automatic set_req(input int sel, input logic v);
    if (sel != 0) req_b = v;
    else req_a = v;
  endtask

  // Random bus activity that a busy slave must ignore (about half out of window).
  task automatic scramble(input int sel);
    set_req(sel, 1'($urandom_range(0, 1)));
    we    = 1'($urandom_range(0, 1));
    addr  = BASE + 32'($urandom_range(0, 2047));
    wdata = $urandom;
  endtask

  // One complete access: acceptance, wait cycles, DONE with scoreboard compare.
  task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d);
    int wc  = (sel != 0) ? 0 : 2;
    int idx = int'((a - BASE) >> 2);
    set_req(sel, 1'b1);
    we    = w;
    addr  = a;
    wdata = d;
    if (w) begin
      if (sel != 0) mem_b[idx] = d;
      else mem_a[idx] = d;
      sb_q.push_back(32'h0);
    end else begin
      sb_q.push_back(model_rd(sel, idx));
    end
    settle();
    chk("hold_accept", 32'(o_hold(sel)), 32'h1);
    chk("err_accept", 32'(o_err(sel)), 32'h0);
    chk("data_accept", o_data(sel), 32'h0);
    tick();
    for (int i = 0; i < wc; i++) begin
      scramble(sel);
      settle();
      chk("hold_wait", 32'(o_hold(sel)), 32'h1);
      chk("data_wait", o_data(sel), 32'h0);
      chk("err_wait", 32'(o_err(sel)), 32'h0);
      tick();
    end
    scramble(sel);
    settle();
    chk("hold_done", 32'(o_hold(sel)), 32'h0);
    chk("err_done", 32'(o_err(sel)), 32'h0);
    chk("data_done", o_data(sel), sb_q.pop_front());
    tick();
    set_req(sel, 1'b0);
    we   = 1'b0;
    addr = BASE;
  endtask

  task automatic miss(input int sel, input logic [31:0] a);
    set_req(sel, 1'b1);
    we   = 1'b1;
    addr = a;
    settle();
    chk("miss_err", 32'(o_err(sel)), 32'h1);
    chk("miss_hold", 32'(o_hold(sel)), 32'h0);
    chk("miss_data", o_data(sel), 32'h0);
    tick();
    set_req(sel, 1'b0);
    settle();
    chk("miss_sticky", 32'(o_stk(sel)), 32'h1);
    chk("miss_err_clr", 32'(o_err(sel)), 32'h0);
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    we    = 1'b0;
    addr  = BASE + 32'h10;
    wdata = 32'h0;
    tick();
    settle();
    chk("rst_hold_a", 32'(hold_a), 32'h0);
    chk("rst_hold_b", 32'(hold_b), 32'h0);
    chk("rst_data_a", data_a, 32'h0);
    tick();
    addr = 32'h0;
    settle();
    chk("rst_err_a", 32'(err_a), 32'h0);
    chk("rst_err_b", 32'(err_b), 32'h0);
    tick();
    rst   = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    addr  = BASE;
    settle();
    chk("idle_hold", 32'(hold_a), 32'h0);
    chk("idle_err", 32'(err_a), 32'h0);
    chk("idle_sticky", 32'(stk_a), 32'h0);
    tick();

    // Write/read pairs, neighbours and last word in the window.
    access(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
    access(0, 1'b0, BASE + 32'h10, 32'h0);
    access(0, 1'b1, BASE + 32'h44, 32'h2222_2222);
    access(0, 1'b1, BASE + 32'h40, 32'h1111_1111);
    access(0, 1'b0, BASE + 32'h44, 32'h0);
    access(0, 1'b0, BASE + 32'h40, 32'h0);
    access(0, 1'b0, BASE + 32'h10, 32'h0);
    access(0, 1'b1, BASE + 32'h3FC, 32'hCAFE_F00D);
    access(0, 1'b0, BASE + 32'h3FC, 32'h0);
    chk("sticky_clean", 32'(stk_a), 32'h0);

    // Zero-wait instance: read right after write.
    access(1, 1'b1, BASE, 32'h1234_5678);
    access(1, 1'b0, BASE, 32'h0);
    chk("sticky_clean_b", 32'(stk_b), 32'h0);

    // Out-of-window accesses on both sides of the window.
    miss(0, 32'h1000_0400);
    miss(0, 32'h0FFF_FFFC);
    access(0, 1'b0, BASE + 32'h3FC, 32'h0);
    chk("sticky_hold", 32'(stk_a), 32'h1);

    // Reset during WAIT aborts the write.
    access(0, 1'b1, BASE + 32'h20, 32'h0);
    req_a = 1'b1;
    we    = 1'b1;
    addr  = BASE + 32'h20;
    wdata = 32'hA5A5_A5A5;
    settle();
    chk("rw_acc_hold", 32'(hold_a), 32'h1);
    tick();
    req_a = 1'b0;
    rst   = 1'b1;
    settle();
    chk("rw_rst_hold", 32'(hold_a), 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("rw_idle_hold", 32'(hold_a), 32'h0);
    chk("rw_sticky_clr", 32'(stk_a), 32'h0);
    tick();
    access(0, 1'b0, BASE + 32'h20, 32'h0);

    // Reset during DONE aborts the write as well.
    access(0, 1'b1, BASE + 32'h24, 32'h0);
    req_a = 1'b1;
    we    = 1'b1;
    addr  = BASE + 32'h24;
    wdata = 32'hFFFF_0000;
    tick();
    req_a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    chk("rd_rst_hold", 32'(hold_a), 32'h0);
    chk("rd_rst_data", data_a, 32'h0);
    tick();
    rst = 1'b0;
    access(0, 1'b0, BASE + 32'h24, 32'h0);
    access(0, 1'b0, BASE + 32'h10, 32'h0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rib_wait_slave.md
RIB_WAIT_SLAVE -- requirements
Module: rib_wait_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: byte base address of the slave window.
REQ-002 SHALL have parameter DEPTH, default 256: number of 32-bit words stored; power of two, 4..4096.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: cycles spent in WAIT per access; range 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_i  input  1  bus access request from the core execute stage.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr_i  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port data_i  input  32  write data.
REQ-010 SHALL have port data_o  output  32  read data.
REQ-011 SHALL have port hold_flag_o  output  1  pipeline stall request to the core control unit.
REQ-012 SHALL have port err_o  output  1  combinational out-of-window access indication.
REQ-013 SHALL have port err_sticky_o  output  1  registered, sticky out-of-window flag.

Function
REQ-014 Hit SHALL mean BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH; index = (addr_i - BASE_ADDR) >> 2, log2(DEPTH) bits.
REQ-015 State machine SHALL have three states: IDLE, WAIT, DONE.
REQ-016 IDLE with req_i=1 and hit SHALL capture index, we_i and data_i, load the wait counter with WAIT_CYCLES, and go to WAIT, or to DONE if WAIT_CYCLES=0.
REQ-017 WAIT SHALL decrement the counter each cycle and go to DONE in the cycle after it reads 1; WAIT lasts exactly WAIT_CYCLES cycles.
REQ-018 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-019 A new request SHALL be accepted at the earliest in the IDLE cycle after DONE, so back-to-back accesses are spaced WAIT_CYCLES+2 cycles apart.
REQ-020 hold_flag_o SHALL be 1 in the IDLE acceptance cycle (combinational on req_i and hit) and in every WAIT cycle, and SHALL be 0 in DONE and otherwise.
REQ-021 For an acceptance at cycle T, hold_flag_o SHALL be high for exactly WAIT_CYCLES+1 cycles (T..T+WAIT_CYCLES), and DONE SHALL occur at T+WAIT_CYCLES+1.
REQ-022 In DONE for a captured read, data_o SHALL equal mem[captured index]; in all other cycles data_o SHALL be 32'h0.
REQ-023 For a captured write, mem[captured index] SHALL be updated with the captured data at the clock edge ending DONE, and data_o SHALL remain 0.
REQ-024 The memory SHALL be read at the DONE cycle, so a read issued immediately after a write to the same word SHALL return the new value.
REQ-025 In WAIT and DONE, changes on req_i, we_i, addr_i and data_i SHALL be ignored; a captured access SHALL always complete, including its write, even if req_i drops.
REQ-026 IDLE with req_i=1 and miss SHALL assert err_o the same cycle, keep hold_flag_o=0, leave the state in IDLE, and perform no memory access.
REQ-027 err_sticky_o SHALL set at the edge after any cycle with err_o=1 and SHALL clear only on rst.
REQ-028 req_i=0 in IDLE SHALL produce no state change, with hold_flag_o=0 and err_o=0.

Reset
REQ-029 rst=1 SHALL force state to IDLE, the counter to 0, err_sticky_o to 0, and capture registers to 0.
REQ-030 During rst=1, hold_flag_o, err_o and data_o SHALL be 0.
REQ-031 Reset mid-access (WAIT or DONE) SHALL abort the access with no memory write.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 Write then read, WAIT_CYCLES=2: write 32'hDEADBEEF to 32'h1000_0010 at T0 -> hold high T0..T2, DONE T3; read same address at T4 -> hold high T4..T6, data_o=32'hDEADBEEF at T7 only.
REQ-034 Zero wait, WAIT_CYCLES=0: read 32'h1000_0000 after writing 32'h12345678 there -> hold high in the acceptance cycle only, data_o=32'h12345678 the next cycle.
REQ-035 Out-of-window: req_i=1, addr_i=32'h1000_0400, DEPTH=256 -> err_o=1 that cycle, hold_flag_o=0, err_sticky_o=1 next cycle and remains 1 until rst.
REQ-036 Input change mid-access: after write acceptance, change addr_i and data_i and drop req_i during WAIT -> the originally captured word is written; other words unchanged.
REQ-037 Reset mid-WAIT: write 32'hA5A5A5A5 to 32'h1000_0020 (previously 32'h0), assert rst in WAIT -> next cycle IDLE and hold 0; a later read returns 32'h0.
REQ-038 Boundary: access to the last word 32'h1000_03FC hits; access to 32'h0FFF_FFFC misses with err_o=1.
